biquad_stream: RTL and testbench

BIQUAD_STREAM -- requirements
Module: biquad_stream

---
 rtl/biquad_stream.sv | 356 +++++++++++++++++++++++++++++++++++
 tb/tb_biquad_stream.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/biquad_stream.sv
`default_nettype none
// ============================================================================
// Module   : biquad_stream
// Purpose  : Time-multiplexed direct-form-I biquad IIR filter on a
//            valid/ready sample stream, with a small register port for
//            coefficients, control, status and a processed-sample counter.
//            One sample is in flight at a time: IDLE -> MUL -> ACC -> OUT.
// Ports    : clk, reset_n (async, active-low)
//            in_valid/in_ready/in_data/in_chan     - sample input
//            out_valid/out_ready/out_data/out_chan - filtered output
//            cfg_write/cfg_read/cfg_address/cfg_writedata/cfg_readdata
//                                                  - register port
// Options  : BIQUAD_STREAM_SAT_EN - defined: clamp out-of-range results and
//            flag status.sat; undefined: wrap to the low DATA_W bits.
// Revision : 1.0 - initial release
// ============================================================================
module biquad_stream #(
    parameter int DATA_W     = 16,
    parameter int COEFF_W    = 32,
    parameter int COEFF_FRAC = 30,
    parameter int CHANNELS   = 2,
    parameter int CH_W       = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CH_W-1:0]   in_chan,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CH_W-1:0]   out_chan,
    input  logic              cfg_write,
    input  logic              cfg_read,
    input  logic [3:0]        cfg_address,
    input  logic [31:0]       cfg_writedata,
    output logic [31:0]       cfg_readdata
);

    localparam int PROD_W = DATA_W + COEFF_W;
    localparam int ACC_W  = DATA_W + COEFF_W + 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        ACC  = 2'd2,
        OUT  = 2'd3
    } state_t;

    state_t state_q, state_d;

    // Register-port state
    logic                      enable_q;
    logic                      clr_pend_q;
    logic signed [COEFF_W-1:0] a1_q, a2_q, b0_q, b1_q, b2_q;
    logic                      chan_err_q;
    logic [31:0]               count_q;
    logic [31:0]               rdata_q;
    // Goes high on the first clock after reset so in_ready stays low in reset.
    logic                      alive_q;

    // Per-channel history
    logic signed [DATA_W-1:0]  x1_q [CHANNELS];
    logic signed [DATA_W-1:0]  x2_q [CHANNELS];
    logic signed [DATA_W-1:0]  y1_q [CHANNELS];
    logic signed [DATA_W-1:0]  y2_q [CHANNELS];

    // In-flight sample context, captured at accept
    logic signed [DATA_W-1:0]  x_q, hx1_q, hx2_q, hy1_q, hy2_q;
    logic signed [COEFF_W-1:0] ca1_q, ca2_q, cb0_q, cb1_q, cb2_q;
    logic [CH_W-1:0]           chan_q;
    logic                      bad_q;

    // Products (MUL) and result (ACC)
    logic signed [PROD_W-1:0]  pb0_q, pb1_q, pb2_q, pa1_q, pa2_q;
    logic [DATA_W-1:0]         out_data_q;
    logic [CH_W-1:0]           out_chan_q;

    logic                      accept_w;
    logic                      out_hs_w;
    logic                      clr_now_w;
    logic                      chan_bad_w;
    logic signed [ACC_W-1:0]   acc_w;
    logic [DATA_W-1:0]         res_w;
    logic                      sat_evt_w;
    logic                      sat_rd_w;
    logic [31:0]               rd_w;

    // A channel tag can only be out of range when the tag space exceeds CHANNELS.
    generate
        if ((2 ** CH_W) > CHANNELS) begin : g_chan_chk
            assign chan_bad_w = (32'(in_chan) >= 32'(CHANNELS));
        end else begin : g_chan_full
            assign chan_bad_w = 1'b0;
        end
    endgenerate

    // ------------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        clr_now_w = 1'b0;
        case (state_q)
            IDLE: begin
                clr_now_w = alive_q && clr_pend_q;
                in_ready  = alive_q && enable_q && !clr_pend_q;
                if (in_valid && in_ready) begin
                    state_d = MUL;
                end
            end
            MUL:  state_d = ACC;
            ACC:  state_d = OUT;
            OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign accept_w = in_valid && in_ready;
    assign out_hs_w = out_valid && out_ready;
    assign out_data = out_data_q;
    assign out_chan = out_chan_q;

    // ------------------------------------------------------------------------
    // Accumulate, scale and range-limit
    // ------------------------------------------------------------------------
    assign acc_w = ACC_W'(pb0_q) + ACC_W'(pb1_q) + ACC_W'(pb2_q)
                 - ACC_W'(pa1_q) - ACC_W'(pa2_q);

`ifdef BIQUAD_STREAM_SAT_EN
    logic signed [ACC_W-1:0]    shift_w;
    logic [ACC_W-DATA_W:0]      hi_w;
    logic                       ovf_w;

    assign shift_w = acc_w >>> COEFF_FRAC;
    // In range only when every bit above the DATA_W sign bit matches it.
    assign hi_w    = shift_w[ACC_W-1:DATA_W-1];
    assign ovf_w   = !((&hi_w) || !(|hi_w));

    always_comb begin
        res_w     = shift_w[DATA_W-1:0];
        sat_evt_w = 1'b0;
        if (bad_q) begin
            res_w = '0;
        end else if (ovf_w) begin
            sat_evt_w = 1'b1;
            res_w     = shift_w[ACC_W-1] ? {1'b1, {(DATA_W-1){1'b0}}}
                                         : {1'b0, {(DATA_W-1){1'b1}}};
        end
    end
`else
    always_comb begin
        res_w     = bad_q ? '0 : DATA_W'(acc_w >>> COEFF_FRAC);
        sat_evt_w = 1'b0;
    end
`endif

    // ------------------------------------------------------------------------
    // Datapath: capture at accept, multiply in MUL, sum in ACC
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            x_q        <= '0;
            hx1_q      <= '0;
            hx2_q      <= '0;
            hy1_q      <= '0;
            hy2_q      <= '0;
            ca1_q      <= '0;
            ca2_q      <= '0;
            cb0_q      <= '0;
            cb1_q      <= '0;
            cb2_q      <= '0;
            chan_q     <= '0;
            bad_q      <= 1'b0;
            pb0_q      <= '0;
            pb1_q      <= '0;
            pb2_q      <= '0;
            pa1_q      <= '0;
            pa2_q      <= '0;
            out_data_q <= '0;
            out_chan_q <= '0;
        end else begin
            if (accept_w) begin
                x_q    <= in_data;
                chan_q <= in_chan;
                bad_q  <= chan_bad_w;
                ca1_q  <= a1_q;
                ca2_q  <= a2_q;
                cb0_q  <= b0_q;
                cb1_q  <= b1_q;
                cb2_q  <= b2_q;
                if (chan_bad_w) begin
                    hx1_q <= '0;
                    hx2_q <= '0;
                    hy1_q <= '0;
                    hy2_q <= '0;
                end else begin
                    hx1_q <= x1_q[in_chan];
                    hx2_q <= x2_q[in_chan];
                    hy1_q <= y1_q[in_chan];
                    hy2_q <= y2_q[in_chan];
                end
            end
            if (state_q == MUL) begin
                pb0_q <= PROD_W'(x_q)   * PROD_W'(cb0_q);
                pb1_q <= PROD_W'(hx1_q) * PROD_W'(cb1_q);
                pb2_q <= PROD_W'(hx2_q) * PROD_W'(cb2_q);
                pa1_q <= PROD_W'(hy1_q) * PROD_W'(ca1_q);
                pa2_q <= PROD_W'(hy2_q) * PROD_W'(ca2_q);
            end
            // out_data/out_chan only load here, so they hold through OUT.
            if (state_q == ACC) begin
                out_data_q <= res_w;
                out_chan_q <= chan_q;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Channel history: commit on the output handshake, zero on clear
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < CHANNELS; i++) begin
                x1_q[i] <= '0;
                x2_q[i] <= '0;
                y1_q[i] <= '0;
                y2_q[i] <= '0;
            end
        end else if (clr_now_w) begin
            for (int i = 0; i < CHANNELS; i++) begin
                x1_q[i] <= '0;
                x2_q[i] <= '0;
                y1_q[i] <= '0;
                y2_q[i] <= '0;
            end
        end else if (out_hs_w && !bad_q) begin
            x1_q[chan_q] <= x_q;
            x2_q[chan_q] <= x1_q[chan_q];
            y1_q[chan_q] <= out_data_q;
            y2_q[chan_q] <= y1_q[chan_q];
        end
    end

    // ------------------------------------------------------------------------
    // Register port
    // ------------------------------------------------------------------------
`ifdef BIQUAD_STREAM_SAT_EN
    logic sat_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sat_q <= 1'b0;
        end else begin
            if (cfg_write && cfg_address == 4'd7 && cfg_writedata[1]) begin
                sat_q <= 1'b0;
            end
            if (state_q == ACC && sat_evt_w) begin
                sat_q <= 1'b1;
            end
        end
    end

    assign sat_rd_w = sat_q;
`else
    assign sat_rd_w = sat_evt_w;
`endif

    // Read mux sees pre-edge values, so a same-cycle write is not visible.
    always_comb begin
        rd_w = '0;
        case (cfg_address)
            4'd0:    rd_w = {30'd0, clr_pend_q, enable_q};
            4'd1:    rd_w = 32'(a1_q);
            4'd2:    rd_w = 32'(a2_q);
            4'd3:    rd_w = 32'(b0_q);
            4'd4:    rd_w = 32'(b1_q);
            4'd5:    rd_w = 32'(b2_q);
            4'd6:    rd_w = count_q;
            4'd7:    rd_w = {29'd0, chan_err_q, sat_rd_w, (state_q != IDLE)};
            default: rd_w = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            enable_q   <= 1'b1;
            clr_pend_q <= 1'b0;
            a1_q       <= '0;
            a2_q       <= '0;
            b0_q       <= COEFF_W'(1) << COEFF_FRAC;
            b1_q       <= '0;
            b2_q       <= '0;
            chan_err_q <= 1'b0;
            count_q    <= '0;
            rdata_q    <= '0;
            alive_q    <= 1'b0;
        end else begin
            alive_q <= 1'b1;
            if (clr_now_w) begin
                clr_pend_q <= 1'b0;
            end
            if (cfg_write) begin
                case (cfg_address)
                    4'd0: begin
                        enable_q <= cfg_writedata[0];
                        if (cfg_writedata[1]) begin
                            clr_pend_q <= 1'b1;
                        end
                    end
                    4'd1: a1_q <= cfg_writedata[COEFF_W-1:0];
                    4'd2: a2_q <= cfg_writedata[COEFF_W-1:0];
                    4'd3: b0_q <= cfg_writedata[COEFF_W-1:0];
                    4'd4: b1_q <= cfg_writedata[COEFF_W-1:0];
                    4'd5: b2_q <= cfg_writedata[COEFF_W-1:0];
                    4'd7: begin
                        if (cfg_writedata[2]) begin
                            chan_err_q <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
            // A new error in the same cycle as a clear-write wins.
            if (accept_w && chan_bad_w) begin
                chan_err_q <= 1'b1;
            end
            if (out_hs_w) begin
                count_q <= count_q + 32'd1;
            end
            if (cfg_read) begin
                rdata_q <= rd_w;
            end
        end
    end

    assign cfg_readdata = rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_biquad_stream.sv
`default_nettype none
// ============================================================================
// Module   : tb_biquad_stream
// Purpose  : Directed self-checking bench for biquad_stream. A reference
//            model computes each expected output when a sample is driven and
//            queues it; outputs are popped and compared on the handshake.
//            Honours BIQUAD_STREAM_SAT_EN for saturate vs. wrap expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_biquad_stream;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_data = '0;
    logic [0:0]  in_chan = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_data;
    logic [0:0]  out_chan;
    logic        cfg_write = 1'b0;
    logic        cfg_read = 1'b0;
    logic [3:0]  cfg_address = '0;
    logic [31:0] cfg_writedata = '0;
    logic [31:0] cfg_readdata;

    always #5 clk = ~clk;

    biquad_stream #(
        .DATA_W     (16),
        .COEFF_W    (32),
        .COEFF_FRAC (30),
        .CHANNELS   (2),
        .CH_W       (1)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_data       (in_data),
        .in_chan       (in_chan),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .out_chan      (out_chan),
        .cfg_write     (cfg_write),
        .cfg_read      (cfg_read),
        .cfg_address   (cfg_address),
        .cfg_writedata (cfg_writedata),
        .cfg_readdata  (cfg_readdata)
    );

    int          checks = 0;
    int          failures = 0;
    logic [16:0] sb[$];
    longint      m_a1, m_a2, m_b0, m_b1, m_b2;
    longint      m_x1[2], m_x2[2], m_y1[2], m_y2[2];
    bit          m_sat;
    int          n_out;
    logic [31:0] rd;
    logic [15:0] exp_hold;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear_hist();
        for (int c = 0; c < 2; c++) begin
            m_x1[c] = 0; m_x2[c] = 0; m_y1[c] = 0; m_y2[c] = 0;
        end
    endtask

    task automatic model_reset();
        m_a1 = 0; m_a2 = 0; m_b1 = 0; m_b2 = 0;
        m_b0 = 64'sd1073741824;
        m_sat = 1'b0;
        n_out = 0;
        model_clear_hist();
    endtask

    task automatic model_push(input int ch, input longint x);
        longint      acc;
        longint      y;
        logic [15:0] r;
        acc = m_b0 * x + m_b1 * m_x1[ch] + m_b2 * m_x2[ch]
            - m_a1 * m_y1[ch] - m_a2 * m_y2[ch];
        y = acc >>> 30;
`ifdef BIQUAD_STREAM_SAT_EN
        if (y > 32767) begin
            y = 32767; m_sat = 1'b1;
        end else if (y < -32768) begin
            y = -32768; m_sat = 1'b1;
        end
`endif
        r = y[15:0];
        m_x2[ch] = m_x1[ch];
        m_x1[ch] = x;
        m_y2[ch] = m_y1[ch];
        m_y1[ch] = longint'($signed(r));
        sb.push_back({ch[0], r});
    endtask

    // Called at a negedge; the write lands on the following posedge.
    task automatic cfg_wr(input logic [3:0] a, input logic [31:0] d);
        cfg_write = 1'b1; cfg_address = a; cfg_writedata = d;
        case (a)
            4'd0: if (d[1]) model_clear_hist();
            4'd1: m_a1 = longint'($signed(d));
            4'd2: m_a2 = longint'($signed(d));
            4'd3: m_b0 = longint'($signed(d));
            4'd4: m_b1 = longint'($signed(d));
            4'd5: m_b2 = longint'($signed(d));
            4'd7: if (d[1]) m_sat = 1'b0;
            default: ;
        endcase
        @(negedge clk);
        cfg_write = 1'b0;
    endtask

    task automatic cfg_rd(input logic [3:0] a, output logic [31:0] d);
        cfg_read = 1'b1; cfg_address = a;
        @(negedge clk);
        d = cfg_readdata;
        cfg_read = 1'b0;
    endtask

    // Returns at the first negedge after the accepting posedge (state MUL).
    task automatic send(input int ch, input int x);
        int n = 0;
        @(negedge clk);
        while (in_ready !== 1'b1 && n < 50) begin
            @(negedge clk); n++;
        end
        if (in_ready !== 1'b1) begin
            checks++; failures++;
            $error("FAIL send_timeout observed in_ready=%b expected=1", in_ready);
        end else begin
            in_valid = 1'b1; in_chan = ch[0]; in_data = x[15:0];
            model_push(ch, longint'(x));
            @(negedge clk);
            in_valid = 1'b0;
        end
    endtask

    task automatic recv();
        int          n = 0;
        logic [16:0] e;
        while (out_valid !== 1'b1 && n < 50) begin
            @(negedge clk); n++;
        end
        if (out_valid !== 1'b1) begin
            checks++; failures++;
            $error("FAIL recv_timeout observed out_valid=%b expected=1", out_valid);
        end else if (sb.size() == 0) begin
            checks++; failures++;
            $error("FAIL recv_unexpected observed data=0x%0h expected=no output", out_data);
        end else begin
            e = sb.pop_front();
            check("out_data", 64'(out_data), 64'(e[15:0]));
            check("out_chan", 64'(out_chan), 64'(e[16]));
            n_out++;
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        model_reset();

        // ---------------- reset state ----------------
        #1 reset_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_readdata", 64'(cfg_readdata), 64'd0);
        reset_n = 1'b1;
        @(negedge clk);
        cfg_rd(4'd3, rd);
        check("rst_b0", 64'(rd), 64'h40000000);
        cfg_rd(4'd0, rd);
        check("rst_ctrl", 64'(rd), 64'd1);

        // ---------------- identity + latency ----------------
        send(0, 1234);
        check("lat_t1", 64'(out_valid), 64'd0);
        @(negedge clk);
        check("lat_t2", 64'(out_valid), 64'd0);
        @(negedge clk);
        check("lat_t3", 64'(out_valid), 64'd1);
        recv();
        cfg_rd(4'd6, rd);
        check("count_1", 64'(rd), 64'd1);

        // ---------------- FIR half-gain taps ----------------
        cfg_wr(4'd0, 32'h3);
        cfg_wr(4'd3, 32'h20000000);
        cfg_wr(4'd4, 32'h20000000);
        cfg_wr(4'd5, 32'h20000000);
        send(0, 100); recv();
        send(0, 200); recv();
        send(0, 300); recv();

        // ---------------- feedback, channel isolation, clear ----------------
        cfg_wr(4'd0, 32'h3);
        cfg_wr(4'd1, 32'hE0000000);
        cfg_wr(4'd3, 32'h40000000);
        cfg_wr(4'd4, 32'h0);
        cfg_wr(4'd5, 32'h0);
        send(0, 100); recv();
        send(1, 40);  recv();
        send(0, 0);   recv();
        cfg_wr(4'd0, 32'h3);
        send(0, 0);   recv();

        // ---------------- coefficient write in flight + backpressure ----------------
        send(1, 7);
        cfg_wr(4'd3, 32'h20000000);  // lands in MUL; must not affect this sample
        while (out_valid !== 1'b1) @(negedge clk);
        exp_hold = sb[0][15:0];
        for (int i = 0; i < 5; i++) begin
            check("hold_data", 64'(out_data), 64'(exp_hold));
            check("hold_in_ready", 64'(in_ready), 64'd0);
            @(negedge clk);
        end
        recv();
        check("post_hs_in_ready", 64'(in_ready), 64'd1);
        check("post_hs_out_valid", 64'(out_valid), 64'd0);
        send(1, 7); recv();  // new b0 applies from here

        // ---------------- overflow ----------------
        cfg_wr(4'd0, 32'h3);
        cfg_wr(4'd1, 32'h0);
        cfg_wr(4'd3, 32'h40000000);
        cfg_wr(4'd4, 32'h40000000);
        cfg_wr(4'd7, 32'h7);
        send(0, 30000); recv();
        send(0, 30000); recv();
        cfg_rd(4'd7, rd);
        check("status_sat", 64'(rd), 64'({m_sat, 1'b0}));
        cfg_rd(4'd6, rd);
        check("count_n", 64'(rd), 64'(n_out));

        // ---------------- same-cycle write and read ----------------
        cfg_write = 1'b1; cfg_read = 1'b1;
        cfg_address = 4'd4; cfg_writedata = 32'h12345678;
        @(negedge clk);
        check("rw_old", 64'(cfg_readdata), 64'h40000000);
        cfg_write = 1'b0; cfg_read = 1'b0;
        m_b1 = 64'sd305419896;
        cfg_rd(4'd4, rd);
        check("rw_new", 64'(rd), 64'h12345678);

        // ---------------- reset during ACC ----------------
        send(0, 500);
        @(negedge clk);               // state ACC
        reset_n = 1'b0;
        #1;
        check("abort_out_valid", 64'(out_valid), 64'd0);
        check("abort_in_ready", 64'(in_ready), 64'd0);
        sb.delete();
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("abort_no_output", 64'(out_valid), 64'd0);
        end
        cfg_rd(4'd3, rd);
        check("abort_b0", 64'(rd), 64'h40000000);
        cfg_rd(4'd6, rd);
        check("abort_count", 64'(rd), 64'd0);
        send(0, 777); recv();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
